// File: rtl/mul_seq.sv
// mul_seq: multi-cycle sequencer for the RV32M multiply group (mul, mulh, mulhsu, mulhu).
// It runs a radix-2 shift-add loop on operand magnitudes, one multiplier bit per cycle.
// It then fixes up the sign of the 64-bit product and registers the selected half.
//
// Optional feature: define MUL_EARLY_OUT_EN so that the loop ends as soon as the remaining
// multiplier bits are all zero. Without it the loop always runs 32 iterations.
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   request, sampled only while ready
//   flush    in   synchronous abort back to idle (highest priority after reset)
//   A        in   multiplicand (rs1)
//   B        in   multiplier (rs2)
//   alu_sel  in   8=mul, 9=mulh, 10=mulhsu, 11=mulhu, others unsupported
//   ready    out  high only in idle
//   busy     out  high while iterating
//   stall    out  busy, or a supported op being accepted this cycle
//   done     out  one-cycle pulse, result valid
//   result   out  registered result, held until the next accepted start
module mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_sel,
    output logic             ready,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    localparam logic [1:0] OpMul = 2'b00;

    logic [1:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic               op_sup;
    logic               a_signed, b_signed;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH-1:0]   mplier_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   res_sel;
    logic               last_iter;

    // Operand decode: codes 8..11 share alu_sel[3:2] == 2'b10.
    always_comb begin
        op_sup   = (alu_sel[3:2] == 2'b10);
        a_signed = ~(alu_sel[1] & alu_sel[0]);  // signed except mulhu
        b_signed = ~alu_sel[1];                 // signed for mul/mulh only
        a_neg    = a_signed & A[WIDTH-1];
        b_neg    = b_signed & B[WIDTH-1];
        // -(-2^31) wraps to 0x8000_0000, which is the correct unsigned magnitude.
        a_mag    = a_neg ? -A : A;
        b_mag    = b_neg ? -B : B;
    end

    // One shift-add step and the sign fix-up applied to the post-step accumulator.
    always_comb begin
        acc_next    = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        mplier_next = mplier_q >> 1;
        prod        = neg_q ? -acc_next : acc_next;
        res_sel     = (op_q == OpMul) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
`ifdef MUL_EARLY_OUT_EN
        last_iter   = (cnt_q == 5'd31) || (mplier_next == '0);
`else
        last_iter   = (cnt_q == 5'd31);
`endif
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;

        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_d = alu_sel[1:0];
                        if (op_sup) begin
                            neg_d    = a_neg ^ b_neg;
                            mcand_d  = {{WIDTH{1'b0}}, a_mag};
                            mplier_d = b_mag;
                            acc_d    = '0;
                            cnt_d    = '0;
                            state_d  = StRun;
                        end else begin
                            result_d = '0;
                            state_d  = StDone;
                        end
                    end
                end
                StRun: begin
                    acc_d    = acc_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_next;
                    cnt_d    = cnt_q + 5'd1;
                    if (last_iter) begin
                        result_d = res_sel;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            neg_q    <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        ready  = (state_q == StIdle);
        busy   = (state_q == StRun);
        done   = (state_q == StDone);
        stall  = busy | (start & ready & op_sup);
        result = result_q;
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: directed self-checking bench for mul_seq.
module tb_mul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  alu_sel;
    logic        ready;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_err = 0;

    mul_seq #(.WIDTH(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .flush   (flush),
        .A       (A),
        .B       (B),
        .alu_sel (alu_sel),
        .ready   (ready),
        .busy    (busy),
        .stall   (stall),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Cycle (relative to accept C0) in which done is expected.
    function automatic int exp_lat(input logic [31:0] b, input logic [3:0] sel);
        if (sel[3:2] != 2'b10) return 1;
`ifdef MUL_EARLY_OUT_EN
        begin
            logic [31:0] mag;
            int          k;
            mag = (!sel[1] && b[31]) ? -b : b;
            if (mag == 32'd0) return 2;
            k = 0;
            for (int i = 0; i < 32; i++) if (mag[i]) k = i;
            return k + 2;
        end
`else
        return 33;
`endif
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] sel, input logic [31:0] exp);
        int lat;
        int done_c;
        int stall_bad;
        logic sup;
        lat = exp_lat(b, sel);
        sup = (sel[3:2] == 2'b10);
        A = a;
        B = b;
        alu_sel = sel;
        start = 1'b1;
        #1;
        check({tag, "_ready_c0"}, {31'd0, ready}, 32'd1);
        check({tag, "_stall_c0"}, {31'd0, stall}, {31'd0, sup});
        @(posedge clk);
        #1;
        start = 1'b0;
        done_c = -1;
        stall_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                done_c = c;
                if (stall) stall_bad++;
                break;
            end
            if (stall !== sup) stall_bad++;
        end
        check({tag, "_done_cycle"}, done_c, lat);
        check({tag, "_result"}, result, exp);
        check({tag, "_stall_seq"}, stall_bad, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_ready_after"}, {31'd0, ready}, 32'd1);
    endtask

    initial begin
        int   lat;
        int   accepts;
        int   dones;
        int   second_acc;
        int   bad;
        rst_n   = 1'b0;
        start   = 1'b0;
        flush   = 1'b0;
        A       = '0;
        B       = '0;
        alu_sel = '0;

        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        do_op("mul_7xm3", 32'h0000_0007, 32'hFFFF_FFFD, 4'd8, 32'hFFFF_FFEB);
        do_op("mulh_min", 32'h8000_0000, 32'h8000_0000, 4'd9, 32'h4000_0000);
        do_op("mulhu_min", 32'h8000_0000, 32'h8000_0000, 4'd11, 32'h4000_0000);
        do_op("mulhsu_min", 32'h8000_0000, 32'h8000_0000, 4'd10, 32'hC000_0000);
        do_op("mulhu_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd11, 32'hFFFF_FFFE);
        do_op("mul_shift", 32'h1234_5678, 32'h0000_0010, 4'd8, 32'h2345_6780);
        do_op("mul_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd8, 32'h0000_0001);
        do_op("mulh_m1m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd9, 32'h0000_0000);
        do_op("mulhsu_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd10, 32'hFFFF_FFFF);
        do_op("mul_b0", 32'h0000_0005, 32'h0000_0000, 4'd8, 32'h0000_0000);
        do_op("mul_big", 32'h0000_0003, 32'h4000_0000, 4'd8, 32'hC000_0000);

        // Flush in C10 with start held high; result keeps 0xC000_0000.
        A = 32'h0000_0005;
        B = 32'h4000_0000;
        alu_sel = 4'd8;
        start = 1'b1;
        @(posedge clk);
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (done) bad++;
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        if (done) bad++;
        check("flush_no_done", bad, 32'd0);
        check("flush_ready", {31'd0, ready}, 32'd1);
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_result", result, 32'hC000_0000);
        // start still high: accepted in this cycle.
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = exp_lat(32'h4000_0000, 4'd8);
        bad = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done) begin
                bad = c;
                break;
            end
        end
        check("flush_next_lat", bad, lat);
        check("flush_next_result", result, 32'h4000_0000);
        @(negedge clk);

        // Asynchronous reset in C5 of a running op.
        A = 32'h0000_0003;
        B = 32'h4000_0000;
        alu_sel = 4'd8;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("arst_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ready", {31'd0, ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op("unsup_3", 32'h0000_0007, 32'h0000_0009, 4'd3, 32'h0000_0000);

        // Back-to-back with start held: accepts at C0 and C(lat+1) only.
        lat = exp_lat(32'hFFFF_FFFD, 4'd8);
        A = 32'h0000_0007;
        B = 32'hFFFF_FFFD;
        alu_sel = 4'd8;
        start = 1'b1;
        accepts = 0;
        dones = 0;
        second_acc = -1;
        bad = 0;
        for (int c = 0; c < 2 * (lat + 1); c++) begin
            #1;
            if (ready && start) begin
                accepts++;
                if (c != 0) second_acc = c;
            end
            if (done) begin
                dones++;
                if (result !== 32'hFFFF_FFEB) bad++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_accepts", accepts, 32'd2);
        check("b2b_second_accept", second_acc, lat + 1);
        check("b2b_dones", dones, 32'd2);
        check("b2b_results", bad, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("b2b_idle", {31'd0, ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mul_seq.md
# mul_seq

Multi-cycle sequencer for the RV32M multiply group (mul, mulh, mulhsu, mulhu). The single-cycle ALU does not implement these opcodes, so this block carries them. It sits beside the ALU in the execute stage. It accepts one operation per start/ready handshake, runs a radix-2 shift-add loop over 32 cycles, and returns a registered 32-bit result with a one-cycle done pulse. While it runs, it holds the pipeline stall line high.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request; sampled only when `ready`=1.
- `flush` in 1: synchronous abort; returns the block to IDLE.
- `A` in 32: multiplicand (rs1).
- `B` in 32: multiplier (rs2).
- `alu_sel` in 4: 8=mul, 9=mulh, 10=mulhsu, 11=mulhu; any other code is unsupported.
- `ready` out 1: high only in IDLE.
- `busy` out 1: high in RUN.
- `stall` out 1: `busy` OR (`start` AND `ready` AND supported `alu_sel`).
- `done` out 1: one-cycle pulse; `result` is valid in that cycle.
- `result` out 32: registered result; held until the next accepted start.

## Operation
- States and transitions:
  - IDLE → RUN on `start` with a supported op.
  - IDLE → DONE on `start` with an unsupported op.
  - RUN → DONE after the final iteration.
  - DONE → IDLE unconditionally.
- Accept edge (IDLE, `start`=1): latch `op`, then prepare operands.
  - Signedness: A is signed for mul/mulh/mulhsu; B is signed for mul/mulh only.
  - `neg` = sign(A_eff) XOR sign(B_eff).
  - Load the magnitudes: `mcand` (64-bit, zero-extended |A|) and `mplier` (32-bit |B|).
  - Clear `acc` (64-bit) and `cnt` (5-bit).
  - |−2^31| = 0x8000_0000 as an unsigned magnitude; no overflow.
- Each RUN cycle:
  - If `mplier[0]`, then `acc += mcand`.
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
- Final iteration is `cnt`==31 (without early-out). On that edge, register `result`:
  - `p = neg ? -acc_next : acc_next`, using 64-bit two's complement.
  - mul: `result = p[31:0]`; all other ops: `result = p[63:32]`.
- Unsupported op: `result` ← 0, go to DONE; `stall` is not asserted.
- `flush` has priority over everything except reset:
  - Forces IDLE and clears `cnt`.
  - `result` keeps its old value and `done` stays low.
  - `start` in the same cycle as `flush` is ignored.
- `start` outside IDLE is ignored; no queuing.
- Reset values: state=IDLE, `ready`=1, `busy`=0, `stall`=0, `done`=0, `result`=0, internal registers 0.
- `rst_n` asserted mid-RUN aborts immediately (asynchronously); there is no `done` for the aborted op.

## Timing
- C0 is the accept cycle (`start`·`ready` high). RUN occupies C1–C32; `done`=1 and `result` is valid in C33; `ready`=1 again in C34.
- Latency is 33 cycles; the initiation interval is 34 cycles.
- Unsupported op: `done` in C1, `ready` in C2.
- `stall` is high combinationally in C0, then through C1–C32; it is low in C33, so the pipeline captures `result` in the `done` cycle.
- `done` is never high for two consecutive cycles.

## Configuration
- `MUL_EARLY_OUT_EN` defined:
  - RUN also exits to DONE on any iteration where the shifted `mplier` becomes 0.
  - Minimum is 1 iteration. If bit k is the highest set bit of |B|, `done` comes in C(k+2); |B|=0 gives `done` in C2.
  - Results are identical to full iteration.
- Undefined: always 32 iterations; fixed 33-cycle latency.

## Test plan
- mul: A=0x0000_0007, B=0xFFFF_FFFD (−3) → `done` in C33 (C3 with EN), `result`=0xFFFF_FFEB.
- mulh: A=0x8000_0000, B=0x8000_0000 → `result`=0x4000_0000. mulhu, same operands → 0x4000_0000. mulhsu, same operands → 0xC000_0000.
- mulhu: A=B=0xFFFF_FFFF → `result`=0xFFFF_FFFE; `stall` high C0–C32, low in C33; `ready` returns in C34.
- `flush` asserted in C10 of a mul, with `start` held high → IDLE in C11, no `done`, `result` unchanged; the next start is accepted normally.
- `rst_n` pulsed low in C5 → all outputs take reset values immediately; an unsupported `alu_sel`=4'd3 started after reset → `done` in C1, `result`=0, `stall` never high.
- Back-to-back starts held high continuously → accepts only in C0 and C34; exactly one `done` per accepted op.
